// File: rtl/parity_frame_rx_pkg.sv
// Shared types and constants for the parity-protected serial frame receiver.
package parity_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter must reach DATA_W without wrapping.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/parity_frame_rx_acc.sv
// Single-bit running XOR accumulator with load-on-clear and enable.
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic init_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;
    logic acc_d;

    // Clear wins over accumulate so a frame start always reloads the seed.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = init_i;
        end else if (en_i) begin
            acc_d = acc_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Receiver for LSB-first frames: start(0), DATA_W data bits, parity, stop(1).
// Delivers the word with parity/framing flags as a one-cycle valid pulse.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;

    logic              acc_clr;
    logic              acc_init;
    logic              acc_en;
    logic              acc;

    parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr),
        .init_i (acc_init),
        .en_i   (acc_en),
        .bit_i  (in_bit),
        .acc_o  (acc)
    );

    // Next-state, datapath and output-latch decisions; flush outranks in_valid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        out_valid_d = 1'b0;
        acc_clr     = 1'b0;
        acc_init    = 1'b0;
        acc_en      = 1'b0;

        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            acc_clr  = 1'b1;
            acc_init = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_bit == START_BIT) begin
                        state_d  = ST_DATA;
                        cnt_d    = '0;
                        acc_clr  = 1'b1;
                        acc_init = PARITY_ODD;
                    end
                end
                ST_DATA: begin
                    // Right-shift so the first (LSB) bit ends at bit 0.
                    shift_d = {in_bit, shift_q[DATA_W-1:1]};
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    acc_en  = 1'b1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    out_data_d  = shift_q;
                    perr_d      = acc;
                    ferr_d      = (in_bit != STOP_BIT);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even- and odd-parity instances share one serial stream.
module tb_parity_frame_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] out_data [2];
    logic       out_valid [2];
    logic       parity_err [2];
    logic       frame_err [2];
    logic       busy [2];

    int   vec  = 0;
    int   errs = 0;
    rec_t obs_q [2][$];
    rec_t exp_q [2][$];

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .parity_err(parity_err[0]),
        .frame_err(frame_err[0]), .busy(busy[0])
    );

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .parity_err(parity_err[1]),
        .frame_err(frame_err[1]), .busy(busy[1])
    );

    // Record every delivered word away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (out_valid[k] === 1'b1) begin
                rec_t r;
                r.d  = out_data[k];
                r.pe = parity_err[k];
                r.fe = frame_err[k];
                obs_q[k].push_back(r);
            end
        end
    end

    // Reference: error when the count of ones in data+parity disagrees with the mode.
    function automatic rec_t model(input logic [7:0] d, input logic p, input logic s, input bit odd);
        int   ones;
        rec_t r;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(p);
        r.d  = d;
        r.pe = ((ones % 2) == 1) != odd;
        r.fe = (s == 1'b0);
        return r;
    endfunction

    task automatic drive(input logic v, input logic b);
        @(posedge clk);
        #1;
        in_valid = v;
        in_bit   = b;
    endtask

    task automatic settle(input int n);
        repeat (n) drive(1'b0, 1'b1);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, bits[i]);
            if (max_gap > 0 && i < 10) begin
                repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'($urandom % 2));
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int max_gap);
        send_bits({s, p, d, 1'b0}, 11, max_gap);
        exp_q[0].push_back(model(d, p, s, 1'b0));
        exp_q[1].push_back(model(d, p, s, 1'b1));
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            vec++;
            if ({out_data[k], out_valid[k], parity_err[k], frame_err[k], busy[k]} !== 12'h0) begin
                errs++;
                $display("FAIL reset_state dut%0d: got data=%h v=%b pe=%b fe=%b busy=%b want all 0",
                         k, out_data[k], out_valid[k], parity_err[k], frame_err[k], busy[k]);
            end
        end
    endtask

    task automatic test_basic();
        repeat (3) drive(1'b1, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        drive(1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (out_valid[k] !== 1'b1 || busy[k] !== 1'b0) begin
                errs++;
                $display("FAIL basic_latency dut%0d: got v=%b busy=%b want v=1 busy=0", k, out_valid[k], busy[k]);
            end
        end
        settle(1);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (out_valid[k] !== 1'b0 || out_data[k] !== 8'hA5) begin
                errs++;
                $display("FAIL basic_hold dut%0d: got v=%b data=%h want v=0 data=a5", k, out_valid[k], out_data[k]);
            end
        end
        settle(2);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL basic_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL basic_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL parity_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL parity_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL frame_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL frame_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h3C, 1'b0, 1'b1, 5);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL b2b_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL b2b_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bits({6'b0, 4'($urandom), 1'b0}, 5, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            vec++;
            if ({out_data[k], out_valid[k], parity_err[k], frame_err[k], busy[k]} !== 12'h0) begin
                errs++;
                $display("FAIL reset_mid dut%0d: got data=%h v=%b pe=%b fe=%b busy=%b want all 0",
                         k, out_data[k], out_valid[k], parity_err[k], frame_err[k], busy[k]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, 0);
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL reset_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL reset_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_flush();
        send_bits({7'b0, 3'b101, 1'b0}, 4, 0);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (busy[k] !== 1'b1) begin
                errs++;
                $display("FAIL flush_busy_pre dut%0d: got %b want 1", k, busy[k]);
            end
        end
        // Flush with a coincident start-looking bit: flush must win.
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (busy[k] !== 1'b0) begin
                errs++;
                $display("FAIL flush_busy_post dut%0d: got %b want 0", k, busy[k]);
            end
        end
        send_frame(8'h80, 1'b1, 1'b1, 0);
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL flush_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL flush_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(2, 0)) drive(1'b1, 1'b1);
            send_frame(8'($urandom), 1'($urandom), ($urandom % 4) != 0, 3);
        end
        settle(3);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errs++;
                $display("FAIL random_count dut%0d: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                vec++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    errs++;
                    $display("FAIL random_word dut%0d #%0d: got %h/%b/%b want %h/%b/%b", k, i,
                             obs_q[k][i].d, obs_q[k][i].pe, obs_q[k][i].fe, exp_q[k][i].d, exp_q[k][i].pe, exp_q[k][i].fe);
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_parity_err();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
